// File: rtl/seq_divider_if.sv
// Run/stall handshake bundle for the iterative divider.
// SEQ_DIVIDER_DZ_EN adds the divide-by-zero flag dz to the bundle.
interface seq_divider_if #(
  parameter int W = 32
);
  logic         run;
  logic         u;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         stall;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
`ifdef SEQ_DIVIDER_DZ_EN
  logic         dz;

  modport master (
    output run, u, x, y,
    input  stall, quot, rem, dz
  );

  modport slave (
    input  run, u, x, y,
    output stall, quot, rem, dz
  );
`else
  modport master (
    output run, u, x, y,
    input  stall, quot, rem
  );

  modport slave (
    input  run, u, x, y,
    output stall, quot, rem
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider: one quotient bit per cycle, floored signed or plain unsigned.
// Optional macro SEQ_DIVIDER_DZ_EN adds the dz divide-by-zero flag on the bus.
module seq_divider #(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic          CLK,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam logic [SW-1:0] S_ZERO = {SW{1'b0}};
  localparam logic [SW-1:0] S_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0] S_LAST = {SW{1'b1}};
  localparam logic [W-1:0]  W_ZERO = {W{1'b0}};
  localparam logic [W-1:0]  W_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  W_ONES = {W{1'b1}};

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    logic [W-1:0] res;
    if (neg) begin
      res = (~v) + W_ONE;
    end else begin
      res = v;
    end
    return res;
  endfunction

  logic [SW-1:0] s_r;
  logic [W:0]    r_r;
  logic [W-1:0]  q_r;

  logic [SW-1:0] s_nxt_s;
  logic [W:0]    r_nxt_s;
  logic [W-1:0]  q_nxt_s;

  logic          first_s;
  logic          last_s;
  logic          x_neg_s;
  logic          y_neg_s;
  logic          sign_diff_s;
  logic [W-1:0]  x_mag_s;
  logic [W-1:0]  d_mag_s;
  logic [W:0]    r_src_s;
  logic [W-1:0]  q_src_s;
  logic [W+1:0]  shifted_s;
  logic [W+1:0]  trial_s;
  logic          q_bit_s;
  logic [W:0]    r_step_s;
  logic [W-1:0]  q_step_s;
  logic [W-1:0]  q_trunc_s;
  logic [W-1:0]  r_trunc_s;
  logic [W-1:0]  quot_s;
  logic [W-1:0]  rem_s;

  // Operand magnitudes and the single restoring step shared by all 32 cycles.
  always_comb begin
    first_s     = (s_r == S_ZERO);
    last_s      = (s_r == S_LAST);
    x_neg_s     = bus.u & bus.x[W-1];
    y_neg_s     = bus.u & bus.y[W-1];
    sign_diff_s = x_neg_s ^ y_neg_s;
    x_mag_s     = cond_neg(bus.x, x_neg_s);
    d_mag_s     = cond_neg(bus.y, y_neg_s);

    if (first_s) begin
      q_src_s = x_mag_s;
      r_src_s = {(W+1){1'b0}};
    end else begin
      q_src_s = q_r;
      r_src_s = r_r;
    end

    // Extra guard bit keeps the sign of the trial subtraction unambiguous.
    shifted_s = {r_src_s, q_src_s[W-1]};
    trial_s   = shifted_s - {2'b00, d_mag_s};

    if (!trial_s[W+1]) begin
      r_step_s = trial_s[W:0];
      q_bit_s  = 1'b1;
    end else begin
      r_step_s = shifted_s[W:0];
      q_bit_s  = 1'b0;
    end
    q_step_s = {q_src_s[W-2:0], q_bit_s};
  end

  // Next-state: advance while run is held, otherwise drop partial work.
  always_comb begin
    s_nxt_s = S_ZERO;
    r_nxt_s = {(W+1){1'b0}};
    q_nxt_s = W_ZERO;
    if (bus.run) begin
      s_nxt_s = s_r + S_ONE;
      r_nxt_s = r_step_s;
      q_nxt_s = q_step_s;
    end else begin
      s_nxt_s = S_ZERO;
      r_nxt_s = {(W+1){1'b0}};
      q_nxt_s = W_ZERO;
    end
  end

  // Step counter and datapath registers.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      s_r <= S_ZERO;
      r_r <= {(W+1){1'b0}};
      q_r <= W_ZERO;
    end else begin
      s_r <= s_nxt_s;
      r_r <= r_nxt_s;
      q_r <= q_nxt_s;
    end
  end

  // Sign correction of the final step: truncated first, then floored.
  always_comb begin
    q_trunc_s = cond_neg(q_step_s, sign_diff_s);
    r_trunc_s = cond_neg(r_step_s[W-1:0], x_neg_s);
    quot_s    = q_trunc_s;
    rem_s     = r_trunc_s;
    if (bus.y == W_ZERO) begin
      quot_s = W_ONES;
      rem_s  = bus.x;
    end else if (sign_diff_s && (r_trunc_s != W_ZERO)) begin
      quot_s = q_trunc_s - W_ONE;
      rem_s  = r_trunc_s + bus.y;
    end else begin
      quot_s = q_trunc_s;
      rem_s  = r_trunc_s;
    end
  end

  assign bus.stall = bus.run & ~last_s;
  assign bus.quot  = (bus.run & last_s) ? quot_s : W_ZERO;
  assign bus.rem   = (bus.run & last_s) ? rem_s  : W_ZERO;

`ifdef SEQ_DIVIDER_DZ_EN
  assign bus.dz = bus.run & last_s & (bus.y == W_ZERO);
`endif

endmodule
